// File: rtl/encrypt_seq.sv
// encrypt_seq: four-round byte permute/XOR cipher sequencer with a valid/ready handshake on each side.
// Define ENCRYPT_CONFIG_MODE_EN to make the permutation and key registers writable over cfg_*.
module encrypt_seq #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [7:0]       in_data,
  input  logic             mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [7:0]       out_data,
  output logic             busy,
  input  logic             cfg_we,
  input  logic [3:0]       cfg_addr,
  input  logic [7:0]       cfg_wdata,
  output logic             cfg_err,
  output logic [CNT_W-1:0] blk_cnt
);
  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] R1   = 3'd1;
  localparam logic [2:0] R2   = 3'd2;
  localparam logic [2:0] R3   = 3'd3;
  localparam logic [2:0] R4   = 3'd4;
  localparam logic [2:0] DONE = 3'd5;
  localparam logic [7:0] KEY1_RST = 8'hDE;
  localparam logic [7:0] KEY2_RST = 8'hAD;
  localparam logic [7:0] KEY3_RST = 8'hBE;
  logic [2:0]       state_q, state_d;
  logic [7:0]       work_q, work_d;
  logic             mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       perm [8];
  logic [7:0]       key1, key2, key3;
  logic [7:0]       fwd_perm, inv_perm;
  assign in_ready  = state_q == IDLE;
  assign out_valid = state_q == DONE;
  assign busy      = state_q != IDLE;
  assign out_data  = work_q;
  assign blk_cnt   = cnt_q;
`ifdef ENCRYPT_CONFIG_MODE_EN
  logic cfg_err_q;
  assign cfg_err = cfg_err_q;
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      for (int i = 0; i < 8; i++) perm[i] <= 3'(7 - i);
      key1      <= KEY1_RST;
      key2      <= KEY2_RST;
      key3      <= KEY3_RST;
      cfg_err_q <= 1'b0;
    end else begin
      cfg_err_q <= cfg_we && (busy || cfg_addr > 4'd10);
      if (cfg_we && !busy) begin
        if (cfg_addr < 4'd8) perm[cfg_addr[2:0]] <= cfg_wdata[2:0];
        if (cfg_addr == 4'd8) key1 <= cfg_wdata;
        if (cfg_addr == 4'd9) key2 <= cfg_wdata;
        if (cfg_addr == 4'd10) key3 <= cfg_wdata;
      end
    end
  end
`else
  logic cfg_unused;
  assign cfg_unused = ^{cfg_we, cfg_addr, cfg_wdata};
  assign cfg_err    = 1'b0;
  assign key1       = KEY1_RST;
  assign key2       = KEY2_RST;
  assign key3       = KEY3_RST;
  always_comb begin
    for (int i = 0; i < 8; i++) perm[i] = 3'(7 - i);
  end
`endif
  // A non-bijective table lets later entries overwrite earlier ones in the inverse.
  always_comb begin
    fwd_perm = '0;
    inv_perm = '0;
    for (int i = 0; i < 8; i++) begin
      fwd_perm[i]       = work_q[perm[i]];
      inv_perm[perm[i]] = work_q[i];
    end
  end
  always_comb begin
    state_d = state_q;
    work_d  = work_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: if (in_valid) begin
        state_d = R1;
        work_d  = in_data;
        mode_d  = mode;
      end
      R1: begin
        state_d = R2;
        work_d  = mode_q ? work_q ^ key3 : fwd_perm;
      end
      R2: begin
        state_d = R3;
        work_d  = work_q ^ (mode_q ? key2 : key1);
      end
      R3: begin
        state_d = R4;
        work_d  = work_q ^ (mode_q ? key1 : key2);
      end
      R4: begin
        state_d = DONE;
        work_d  = mode_q ? inv_perm : work_q ^ key3;
      end
      DONE: if (out_ready) begin
        state_d = IDLE;
        cnt_d   = cnt_q + CNT_W'(1);
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      work_q  <= '0;
      mode_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      work_q  <= work_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_encrypt_seq.sv
// tb_encrypt_seq: scoreboard bench for encrypt_seq; a narrow counter makes the blk_cnt wrap reachable quickly.
module tb_encrypt_seq;
  localparam int CW = 4;
  logic clk = 0, n_rst = 0, in_valid = 0, mode = 0, out_ready = 1, cfg_we = 0;
  logic [7:0] in_data = 0, cfg_wdata = 0;
  logic [3:0] cfg_addr = 0;
  logic in_ready, out_valid, busy, cfg_err;
  logic [7:0] out_data;
  logic [CW-1:0] blk_cnt;
  int checks = 0, fails = 0, cyc = 0, acc_n = 0, acc_cyc = -100;
  logic [7:0] exp_q[$];
  logic [CW-1:0] exp_cnt = 0;
  logic pv = 0, saw_wrap = 0;
  logic [7:0] pd = 0;

  encrypt_seq #(.CNT_W(CW)) dut (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .mode(mode), .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .busy(busy),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_err(cfg_err), .blk_cnt(blk_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic expire(input string name);
    checks++;
    fails++;
    $display("FAIL %s actual=timeout required=event", name);
  endtask

  // Monitor: scoreboard pop, counter model, latency and DONE-hold checks.
  always @(negedge clk) begin
    if (!n_rst) begin
      exp_cnt = '0;
      pv = 0;
    end else begin
      chk("blk_cnt", blk_cnt, exp_cnt);
      if (out_valid) begin
        if (!pv) chk("latency", cyc - acc_cyc, 5);
        else chk("hold_data", out_data, pd);
        chk("in_ready_in_done", in_ready, 0);
      end
      if (in_valid && in_ready) begin
        acc_n++;
        acc_cyc = cyc;
      end
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) expire("unexpected_output");
        else chk("out_data", out_data, exp_q.pop_front());
        if (exp_cnt == '1) saw_wrap = 1;
        exp_cnt++;
      end
      pv = out_valid;
      pd = out_data;
    end
  end

  task automatic send(input logic [7:0] d, input logic m, input logic [7:0] e);
    int n = 0;
    in_data = d;
    mode = m;
    in_valid = 1;
    @(negedge clk);
    while (!in_ready && n < 60) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) expire("accept_wait");
    else exp_q.push_back(e);
    @(posedge clk);
    #1 in_valid = 0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || busy) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) expire("drain_wait");
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_wr(input logic [3:0] a, input logic [7:0] d);
    cfg_addr = a;
    cfg_wdata = d;
    cfg_we = 1;
    @(posedge clk);
    #1 cfg_we = 0;
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #3 n_rst = 0;
    exp_q.delete();
    @(posedge clk);
    #1 n_rst = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    int a0;
    int n;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_cfg_err", cfg_err, 0);
    chk("rst_blk_cnt", blk_cnt, 0);
    @(posedge clk);
    @(posedge clk);
    #1 n_rst = 1;
    // 01 reversed = 80, ^DE ^AD ^BE = 4D
    send(8'h01, 0, 8'h4D);
    drain();
    chk("blk_cnt_first", blk_cnt, 1);
    send(8'h4D, 1, 8'h01);
    send(8'hA5, 0, 8'h68);
    send(8'h68, 1, 8'hA5);
    drain();
    // Backpressure in DONE with a second byte pending
    out_ready = 0;
    send(8'hA5, 0, 8'h68);
    in_data = 8'h11;
    mode = 0;
    in_valid = 1;
    n = 0;
    while (!out_valid && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (!out_valid) expire("stall_valid_wait");
    a0 = acc_n;
    repeat (10) @(negedge clk);
    chk("stall_no_accept", acc_n, a0);
    chk("stall_out_valid", out_valid, 1);
    chk("stall_data", out_data, 8'h68);
    @(posedge clk);
    #1 out_ready = 1;
    send(8'h11, 0, 8'h45);
    drain();
    chk("one_accept_after_release", acc_n, a0 + 1);
    // Reset during R2 drops the in-flight byte
    send(8'h01, 0, 8'h4D);
    @(posedge clk);
    #3 n_rst = 0;
    #1;
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_blk_cnt", blk_cnt, 0);
    chk("midrst_out_data", out_data, 0);
    exp_q.delete();
    @(posedge clk);
    @(posedge clk);
    #1 n_rst = 1;
    send(8'h01, 0, 8'h4D);
    drain();
    chk("post_rst_blk_cnt", blk_cnt, 1);
`ifdef ENCRYPT_CONFIG_MODE_EN
    for (int i = 0; i < 8; i++) cfg_wr(4'(i), 8'(i));
    cfg_wr(4'd8, 8'h00);
    cfg_wr(4'd9, 8'h00);
    cfg_wr(4'd10, 8'h00);
    @(negedge clk);
    chk("cfg_err_good_write", cfg_err, 0);
    @(posedge clk);
    #1;
    send(8'h3C, 0, 8'h3C);
    cfg_addr = 4'd9;
    cfg_wdata = 8'h55;
    cfg_we = 1;
    @(posedge clk);
    #1 cfg_we = 0;
    @(negedge clk);
    chk("cfg_err_busy", cfg_err, 1);
    @(negedge clk);
    chk("cfg_err_pulse_end", cfg_err, 0);
    drain();
    send(8'h3C, 0, 8'h3C);
    drain();
    cfg_wr(4'd12, 8'hAA);
    @(negedge clk);
    chk("cfg_err_bad_addr", cfg_err, 1);
    @(posedge clk);
    #1;
    cfg_addr = 4'd8;
    cfg_wdata = 8'hFF;
    cfg_we = 1;
    send(8'h3C, 0, 8'hC3);
    cfg_we = 0;
    drain();
`else
    cfg_wr(4'd9, 8'h00);
    @(negedge clk);
    chk("cfg_err_tied_idle", cfg_err, 0);
    @(posedge clk);
    #1;
    send(8'h01, 0, 8'h4D);
    cfg_wr(4'd8, 8'h00);
    @(negedge clk);
    chk("cfg_err_tied_busy", cfg_err, 0);
    drain();
    cfg_wr(4'd12, 8'h00);
    @(negedge clk);
    chk("cfg_err_tied_addr", cfg_err, 0);
    @(posedge clk);
    #1;
`endif
    // Reset restores default tables; 17 completions wrap the 4-bit counter to 1
    pulse_reset();
    for (int i = 0; i < 17; i++) send(8'h01, 0, 8'h4D);
    drain();
    chk("blk_cnt_wrap", blk_cnt, 1);
    chk("wrap_seen", saw_wrap, 1);
    chk("queue_empty", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
